// File: rtl/fir_audio_pkg.sv
// Sample/word types and the shift-then-saturate helper shared by the FIR audio sink.
package fir_audio_pkg;

    typedef logic signed [7:0]  sample_t;
    typedef logic signed [31:0] fir_word_t;

    localparam int SAMPLE_MAX = 127;
    localparam int SAMPLE_MIN = -128;

    typedef struct packed {
        sample_t value;
        logic    clipped;
    } sat_result_t;

    // Arithmetic shift rounds toward minus infinity before clamping to the 8-bit range.
    function automatic sat_result_t saturate_shift(input fir_word_t word, input int unsigned shamt);
        fir_word_t   scaled;
        sat_result_t res;
        scaled      = word >>> shamt;
        res.value   = scaled[7:0];
        res.clipped = 1'b0;
        if (scaled > SAMPLE_MAX) begin
            res.value   = sample_t'(SAMPLE_MAX);
            res.clipped = 1'b1;
        end else if (scaled < SAMPLE_MIN) begin
            res.value   = sample_t'(SAMPLE_MIN);
            res.clipped = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous sample FIFO; a push is accepted when full only if a pop happens in the same cycle.
module sample_fifo
    import fir_audio_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int FW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  sample_t       data_i,
    input  logic          pop_i,
    output sample_t       data_o,
    output logic [FW-1:0] fill_o,
    output logic          full_o
);

    localparam int AW = $clog2(DEPTH);

    sample_t       mem [DEPTH];
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          doPush;
    logic          doPop;

    always_comb begin
        doPop   = pop_i && (fill_q != '0);
        doPush  = push_i && ((fill_q != FW'(DEPTH)) || doPop);
        wrPtr_d = doPush ? wrPtr_q + AW'(1) : wrPtr_q;
        rdPtr_d = doPop  ? rdPtr_q + AW'(1) : rdPtr_q;
        fill_d  = fill_q + FW'(doPush) - FW'(doPop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            fill_q  <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            fill_q  <= fill_d;
        end
    end

    // Storage needs no reset: the head is only meaningful while fill is non-zero.
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem[wrPtr_q] <= data_i;
        end
    end

    assign data_o = mem[rdPtr_q];
    assign fill_o = fill_q;
    assign full_o = (fill_q == FW'(DEPTH));

endmodule

// File: rtl/fir_output_sink.sv
// Decimates the non-stallable FIR output stream, scales it to 8-bit audio and queues it behind valid/ready.
module fir_output_sink
    import fir_audio_pkg::*;
#(
    parameter int DECIMATE = 4,
    parameter int SHIFT    = 8,
    parameter int DEPTH    = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         s_axis_data_tvalid,
    input  logic signed [31:0]           s_axis_data_tdata,
    output logic                         m_axis_data_tvalid,
    output logic signed [7:0]            m_axis_data_tdata,
    input  logic                         m_axis_data_tready,
    output logic [$clog2(DEPTH+1)-1:0]   fill_out,
    output logic                         sat_out,
    output logic                         overflow_out
);

    localparam int PW = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
    localparam int FW = $clog2(DEPTH + 1);

    logic [PW-1:0] phase_q, phase_d;
    logic          stageValid_q, stageValid_d;
    sample_t       stageData_q, stageData_d;
    logic          sat_q, sat_d;
    logic          overflow_q, overflow_d;
    logic          keep;
    sat_result_t   shaped;
    logic          pop;
    logic          fifoFull;
    sample_t       fifoHead;
    logic [FW-1:0] fifoFill;

    always_comb begin
        shaped       = saturate_shift(s_axis_data_tdata, SHIFT);
        keep         = s_axis_data_tvalid && (phase_q == '0);
        phase_d      = phase_q;
        if (s_axis_data_tvalid) begin
            phase_d = (phase_q == PW'(DECIMATE - 1)) ? '0 : phase_q + PW'(1);
        end
        stageValid_d = keep;
        stageData_d  = keep ? shaped.value : stageData_q;
        sat_d        = keep && shaped.clipped;
        pop          = m_axis_data_tvalid && m_axis_data_tready;
        // A full FIFO still takes the stage sample when the head leaves in the same cycle.
        overflow_d   = overflow_q || (stageValid_q && fifoFull && !pop);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            phase_q      <= '0;
            stageValid_q <= 1'b0;
            stageData_q  <= '0;
            sat_q        <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            stageValid_q <= stageValid_d;
            stageData_q  <= stageData_d;
            sat_q        <= sat_d;
            overflow_q   <= overflow_d;
        end
    end

    sample_fifo #(
        .DEPTH (DEPTH),
        .FW    (FW)
    ) u_fifo (
        .clk_i  (clk_in),
        .rst_i  (rst_in),
        .push_i (stageValid_q),
        .data_i (stageData_q),
        .pop_i  (pop),
        .data_o (fifoHead),
        .fill_o (fifoFill),
        .full_o (fifoFull)
    );

    assign m_axis_data_tvalid = (fifoFill != '0);
    assign m_axis_data_tdata  = m_axis_data_tvalid ? fifoHead : '0;
    assign fill_out           = fifoFill;
    assign sat_out            = sat_q;
    assign overflow_out       = overflow_q;

endmodule

// File: tb/tb_fir_output_sink.sv
// Three sinks (DECIMATE 4, 1, 3) share one stimulus stream and are checked against a queue-based model.
module tb_fir_output_sink;

    localparam int N     = 3;
    localparam int DEPTH = 4;
    localparam int FW    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sTvalid = 1'b0;
    logic [31:0] sTdata = '0;
    logic        mTready = 1'b0;

    logic          vTvalid [N];
    logic [7:0]    vTdata  [N];
    logic [FW-1:0] vFill   [N];
    logic          vSat    [N];
    logic          vOvf    [N];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        fir_output_sink #(
            .DECIMATE ((g == 0) ? 4 : ((g == 1) ? 1 : 3)),
            .SHIFT    (8),
            .DEPTH    (DEPTH)
        ) dut (
            .clk_in             (clk),
            .rst_in             (rst),
            .s_axis_data_tvalid (sTvalid),
            .s_axis_data_tdata  (sTdata),
            .m_axis_data_tvalid (vTvalid[g]),
            .m_axis_data_tdata  (vTdata[g]),
            .m_axis_data_tready (mTready),
            .fill_out           (vFill[g]),
            .sat_out            (vSat[g]),
            .overflow_out       (vOvf[g])
        );
    end

    // Reference model: pending stage sample, a plain FIFO queue and a sticky drop flag per instance.
    int         decim [N] = '{4, 1, 3};
    int         phase [N] = '{0, 0, 0};
    int         stV   [N] = '{0, 0, 0};
    logic [7:0] stD   [N];
    int         stS   [N] = '{0, 0, 0};
    int         cnt   [N] = '{0, 0, 0};
    int         ovf   [N] = '{0, 0, 0};
    logic [7:0] q     [N][DEPTH];
    longint     y;

    always @(posedge clk or posedge rst) begin
        for (int g = 0; g < N; g++) begin
            if (rst) begin
                phase[g] = 0; stV[g] = 0; stS[g] = 0; cnt[g] = 0; ovf[g] = 0;
            end else begin
                if (cnt[g] > 0 && mTready) begin
                    for (int i = 0; i < DEPTH - 1; i++) q[g][i] = q[g][i+1];
                    cnt[g]--;
                end
                if (stV[g] != 0) begin
                    if (cnt[g] < DEPTH) begin
                        q[g][cnt[g]] = stD[g];
                        cnt[g]++;
                    end else begin
                        ovf[g] = 1;
                    end
                end
                stV[g] = (sTvalid && phase[g] == 0) ? 1 : 0;
                stS[g] = 0;
                if (stV[g] != 0) begin
                    y = longint'($signed(sTdata)) >>> 8;
                    if (y > 127) begin
                        stD[g] = 8'h7F; stS[g] = 1;
                    end else if (y < -128) begin
                        stD[g] = 8'h80; stS[g] = 1;
                    end else begin
                        stD[g] = y[7:0];
                    end
                end
                if (sTvalid) phase[g] = (phase[g] + 1) % decim[g];
            end
        end
    end

    logic [7:0] lg    [N][64];
    int         lgN   [N] = '{0, 0, 0};
    int         satCn [N] = '{0, 0, 0};

    task automatic checkOutput(input string name, input int g, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s[%0d] got=%0h expected=%0h at %0t", name, g, act, exp, $time);
        end
    endtask

    // Every cycle, away from the edge: compare all outputs with the model and log accepted samples.
    always @(negedge clk) begin
        if (!rst) begin
            for (int g = 0; g < N; g++) begin
                checkOutput("tvalid", g, int'(vTvalid[g]), (cnt[g] != 0) ? 1 : 0);
                if (cnt[g] != 0) checkOutput("tdata", g, int'(vTdata[g]), int'(q[g][0]));
                checkOutput("fill", g, int'(vFill[g]), cnt[g]);
                checkOutput("sat", g, int'(vSat[g]), stS[g]);
                checkOutput("overflow", g, int'(vOvf[g]), ovf[g]);
                if (vTvalid[g] && mTready && lgN[g] < 64) begin
                    lg[g][lgN[g]] = vTdata[g];
                    lgN[g]++;
                end
                if (vSat[g]) satCn[g]++;
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r);
        sTvalid = v;
        sTdata  = d;
        mTready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic clearLogs();
        for (int g = 0; g < N; g++) begin
            lgN[g]   = 0;
            satCn[g] = 0;
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        rst = 1'b0;
        clearLogs();
    endtask

    task automatic checkZeroOutputs();
        for (int g = 0; g < N; g++) begin
            checkOutput("rst_tvalid", g, int'(vTvalid[g]), 0);
            checkOutput("rst_tdata", g, int'(vTdata[g]), 0);
            checkOutput("rst_fill", g, int'(vFill[g]), 0);
            checkOutput("rst_sat", g, int'(vSat[g]), 0);
            checkOutput("rst_overflow", g, int'(vOvf[g]), 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkZeroOutputs();
        rst = 1'b0;
        clearLogs();

        // Decimation and scaling
        for (int k = 0; k < 8; k++) applyStimulus(1'b1, 32'(k * 256), 1'b1);
        repeat (4) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("decim_len", 0, lgN[0], 2);
        checkOutput("decim_s0", 0, int'(lg[0][0]), 'h00);
        checkOutput("decim_s1", 0, int'(lg[0][1]), 'h04);
        checkOutput("decim_sat", 0, satCn[0], 0);
        checkOutput("decim1_len", 1, lgN[1], 8);
        checkOutput("decim1_s7", 1, int'(lg[1][7]), 'h07);

        // Saturation
        doReset();
        applyStimulus(1'b1, 32'h0001_0000, 1'b1);
        applyStimulus(1'b1, 32'hFFFF_0000, 1'b1);
        applyStimulus(1'b1, 32'hFFFF_FF80, 1'b1);
        repeat (4) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("sat_len", 1, lgN[1], 3);
        checkOutput("sat_s0", 1, int'(lg[1][0]), 'h7F);
        checkOutput("sat_s1", 1, int'(lg[1][1]), 'h80);
        checkOutput("sat_s2", 1, int'(lg[1][2]), 'hFF);
        checkOutput("sat_pulses", 1, satCn[1], 2);

        // Backpressure and overflow
        doReset();
        for (int k = 1; k <= 6; k++) applyStimulus(1'b1, 32'(k * 256), 1'b0);
        repeat (2) applyStimulus(1'b0, '0, 1'b0);
        checkOutput("bp_fill", 1, int'(vFill[1]), 4);
        checkOutput("bp_overflow", 1, int'(vOvf[1]), 1);
        repeat (6) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("bp_len", 1, lgN[1], 4);
        for (int i = 0; i < 4; i++) checkOutput("bp_order", 1, int'(lg[1][i]), i + 1);
        checkOutput("bp_tvalid", 1, int'(vTvalid[1]), 0);
        checkOutput("bp_sticky", 1, int'(vOvf[1]), 1);

        // Simultaneous push and pop while full
        doReset();
        for (int k = 1; k <= 5; k++) applyStimulus(1'b1, 32'(k * 256), 1'b0);
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("pp_fill", 1, int'(vFill[1]), 4);
        checkOutput("pp_overflow", 1, int'(vOvf[1]), 0);
        repeat (6) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("pp_len", 1, lgN[1], 5);
        for (int i = 0; i < 5; i++) checkOutput("pp_order", 1, int'(lg[1][i]), i + 1);

        // Gaps in tvalid
        doReset();
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(1'b1, 32'(k * 256), 1'b1);
            repeat ($urandom_range(0, 3)) applyStimulus(1'b0, '0, 1'b1);
        end
        repeat (4) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("gap_len", 2, lgN[2], 3);
        checkOutput("gap_s0", 2, int'(lg[2][0]), 1);
        checkOutput("gap_s1", 2, int'(lg[2][1]), 4);
        checkOutput("gap_s2", 2, int'(lg[2][2]), 7);

        // Asynchronous reset in the middle of a stream
        doReset();
        for (int k = 1; k <= 5; k++) applyStimulus(1'b1, 32'(k * 256), 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1);
        mTready = 1'b0;
        checkOutput("mid_fill", 1, int'(vFill[1]), 3);
        checkOutput("mid_overflow", 1, int'(vOvf[1]), 1);
        sTvalid = 1'b1;
        sTdata  = 32'h0000_0A00;
        rst = 1'b1;
        #1;
        checkZeroOutputs();
        #1;
        rst = 1'b0;
        sTvalid = 1'b0;
        clearLogs();
        applyStimulus(1'b1, 32'h0000_0900, 1'b1);
        repeat (4) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("post_len", 1, lgN[1], 1);
        checkOutput("post_s0", 1, int'(lg[1][0]), 'h09);
        checkOutput("post_dec4", 0, int'(lg[0][0]), 'h09);

        // Randomized traffic, checked cycle by cycle against the model
        doReset();
        for (int c = 0; c < 600; c++) begin
            logic [31:0] d;
            if ($urandom_range(0, 3) == 0) d = $urandom;
            else d = 32'($signed($urandom_range(0, 80000)) - 40000);
            applyStimulus($urandom_range(0, 3) != 0, d, (c % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0));
        end
        repeat (8) applyStimulus(1'b0, '0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
